// File: rtl/shift_collector_two_if.sv
// Handshake bundle for shift_collector_two.
//   start        : clear the accumulator and begin a new word
//   digit_in     : next radix-4 digit, least-significant digit first
//   digit_valid  : digit_in is valid this cycle
//   digit_ready  : collector accepts a digit this cycle
//   out_number   : accumulator contents (WIDTH bits)
//   out_valid    : out_number holds a complete word
//   out_ready    : consumer takes the word this cycle
//   busy         : collector is not idle
// master = producer/consumer side, slave = collector side.
interface shift_collector_two_if #(
  parameter int unsigned WIDTH = 1028
);

  logic             start;
  logic [1:0]       digit_in;
  logic             digit_valid;
  logic             digit_ready;
  logic [WIDTH-1:0] out_number;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output start,
    output digit_in,
    output digit_valid,
    output out_ready,
    input  digit_ready,
    input  out_number,
    input  out_valid,
    input  busy
  );

  modport slave (
    input  start,
    input  digit_in,
    input  digit_valid,
    input  out_ready,
    output digit_ready,
    output out_number,
    output out_valid,
    output busy
  );

endinterface

// File: rtl/shift_collector_two.sv
// Radix-4 digit collector: assembles a WIDTH-bit word from WIDTH/2 two-bit
// digits presented least-significant first, then offers the word with a
// valid/ready handshake.
//   clk   : clock, rising edge
//   restn : asynchronous active-low reset
//   bus   : shift_collector_two_if.slave (start, digit stream in,
//           assembled word out, busy)
module shift_collector_two #(
  parameter int unsigned WIDTH  = 1028,
  parameter int unsigned DIGITS = WIDTH / 2
) (
  input  logic                 clk,
  input  logic                 restn,
  shift_collector_two_if.slave bus
);

  // Counter must be able to hold DIGITS itself (the value reached in DONE).
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);

  // Elaboration-time parameter sanity.
  if ((WIDTH % 2) != 0 || WIDTH < 4 || DIGITS != WIDTH / 2) begin : g_param_check
    $error("shift_collector_two: WIDTH must be even and >= 4, DIGITS must equal WIDTH/2");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;

  logic digit_ready_c;
  logic out_valid_c;
  logic busy_c;
  logic accept_c;
  logic clear_c;

  // State register.
  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        // Final digit accepted: word complete on the next edge.
        if (bus.digit_valid && (cnt_q == LAST_CNT)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // start only counts together with the handshake.
        if (bus.out_ready) begin
          state_d = bus.start ? ST_COLLECT : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs and datapath controls, decoded from the current state.
  always_comb begin
    digit_ready_c = 1'b0;
    out_valid_c   = 1'b0;
    busy_c        = 1'b0;
    accept_c      = 1'b0;
    clear_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clear_c = bus.start;
      end
      ST_COLLECT: begin
        digit_ready_c = 1'b1;
        busy_c        = 1'b1;
        accept_c      = bus.digit_valid;
      end
      ST_DONE: begin
        out_valid_c = 1'b1;
        busy_c      = 1'b1;
        clear_c     = bus.start && bus.out_ready;
      end
      default: begin
        digit_ready_c = 1'b0;
      end
    endcase
  end

  // Accumulator and digit counter; new digits enter at the top and shift
  // down so the first digit lands in bits [1:0] after DIGITS accepts.
  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clear_c) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept_c) begin
      acc_q <= {bus.digit_in, acc_q[WIDTH-1:2]};
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bus.digit_ready = digit_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.busy        = busy_c;
  assign bus.out_number  = acc_q;

  // Counter never runs past the digit count.
  a_cnt_bound: assert property (@(posedge clk) disable iff (!restn)
    cnt_q <= CW'(DIGITS));

  // Completed word is held while the consumer stalls.
  a_done_stable: assert property (@(posedge clk) disable iff (!restn)
    (state_q == ST_DONE && !bus.out_ready) |=> $stable(acc_q));

  // DONE is only ever entered with a full digit count.
  a_done_full: assert property (@(posedge clk) disable iff (!restn)
    (state_q == ST_DONE) |-> (cnt_q == CW'(DIGITS)));

endmodule

// File: doc/shift_collector_two.md
SHIFT_COLLECTOR_TWO -- requirements
Module: shift_collector_two

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1028, meaning the assembled word width in bits; it SHALL be even and at least 4.
REQ-002 The block SHALL have parameter DIGITS, default WIDTH/2, meaning the number of 2-bit digits per word; it is derived and SHALL NOT be overridden.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port restn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: clear the accumulator and begin collecting a new word.
REQ-006 The block SHALL have port digit_in, input, 2 bits: the next radix-4 digit, least-significant digit first.
REQ-007 The block SHALL have port digit_valid, input, 1 bit: digit_in is valid this cycle.
REQ-008 The block SHALL have port digit_ready, output, 1 bit: the block accepts a digit this cycle.
REQ-009 The block SHALL have port out_number, output, WIDTH bits: the accumulator register contents.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_number holds a complete word.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the word this cycle.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement exactly three states: IDLE, COLLECT and DONE.
REQ-014 In IDLE: digit_ready=0 and out_valid=0; start=1 SHALL clear the accumulator and digit counter to 0 and move to COLLECT.
REQ-015 In COLLECT: digit_ready SHALL be 1 combinationally, and start SHALL be ignored.
REQ-016 A digit is accepted only on a cycle with digit_valid=1 and digit_ready=1; digit_valid while digit_ready=0 SHALL be ignored, with no buffering.
REQ-017 On accept, accumulator <= {digit_in, accumulator[WIDTH-1:2]}, a right shift inserting at the top, and the counter SHALL increment by 1.
REQ-018 After WIDTH/2 accepts, the first digit SHALL occupy bits [1:0], and out_number SHALL equal sum(d_i * 4^i).
REQ-019 The counter SHALL be ceil(log2(DIGITS+1)) bits wide and SHALL never exceed DIGITS.
REQ-020 When the counter is DIGITS-1 and a digit is accepted, the next state SHALL be DONE, and out_valid SHALL rise on the cycle after that final accept.
REQ-021 Minimum latency from the start cycle to out_valid SHALL be DIGITS+1 cycles, i.e. 515 at the default WIDTH.
REQ-022 Idle cycles with digit_valid=0 in COLLECT SHALL change neither the accumulator nor the counter.
REQ-023 In DONE: out_valid=1, digit_ready=0, and out_number SHALL be held stable until the handshake.
REQ-024 In DONE, out_valid=1 with out_ready=1 SHALL move to IDLE; out_number SHALL retain its value in IDLE until the next start.
REQ-025 In DONE, start=1 together with out_ready=1 SHALL move directly to COLLECT with the accumulator and counter cleared.
REQ-026 In DONE, start=1 with out_ready=0 SHALL be ignored.
REQ-027 out_ready outside DONE SHALL be ignored.
REQ-028 The block SHALL contain no arithmetic beyond the counter increment, and no combinational path from digit_in to out_number.

Reset
REQ-029 restn=0 SHALL, asynchronously and regardless of clk, force state=IDLE, accumulator=0, counter=0, out_number=0, out_valid=0, digit_ready=0 and busy=0.
REQ-030 Reset mid-COLLECT or mid-DONE SHALL discard the partial or complete word.
REQ-031 After restn rises, the block SHALL remain in IDLE until start is sampled high on a rising edge.

Verification
REQ-032 Reset test: assert restn=0 mid-cycle -> all outputs 0 immediately, without waiting for a clk edge.
REQ-033 Basic test (WIDTH=8): start, then digits 01, 10, 11, 00 on consecutive cycles -> out_number=8'h39, with out_valid rising exactly 1 cycle after the 4th accept.
REQ-034 Gap test (WIDTH=8): same digits with digit_valid low for 3 cycles between each digit -> out_number=8'h39, counter advancing only on accepts.
REQ-035 Backpressure test: hold out_ready=0 for 5 cycles in DONE -> out_valid=1, out_number stable, digit_ready=0; then out_ready=1 -> IDLE next cycle; start with out_ready=1 in DONE -> COLLECT, accumulator=0.
REQ-036 Mid-operation reset test (WIDTH=8): reset after 2 accepts, then start followed by digits 11, 11, 11, 11 -> out_number=8'hFF, with no residue from the discarded word.
REQ-037 Round-trip test (WIDTH=1028): feed the 2-bit digit stream of the radix-4 shift register for random X, LSB digit first -> out_number==X for 100 random X, including X=0 and X=all ones.
